// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle click / double-click / long-press pulses.
// Pulses are registered, one cycle after the deciding edge; no backpressure, events are fire-and-forget.
module button_event_decoder #(
  parameter logic [31:0] LONG_TIME = 32'd50_000_000,
  parameter logic [31:0] GAP_TIME  = 32'd15_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  output logic       click_o,
  output logic       dclick_o,
  output logic       long_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        btn_q;
  logic        click_q, click_d;
  logic        dclick_q, dclick_d;
  logic        long_q, long_d;
  logic        rise, fall;

  assign rise = btn_i & ~btn_q;
  assign fall = ~btn_i & btn_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        // Release takes priority over reaching the long-press limit.
        if (!btn_i) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_TIME - 32'd1) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT2: begin
        // A second press on the last gap cycle still counts as a double click.
        if (rise) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_TIME - 32'd1) begin
          state_d = IDLE;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d  = IDLE;
          dclick_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // btn_q resets high so a button held through reset never produces a rise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      btn_q    <= 1'b1;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_i;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
    end
  end

  assign click_o  = click_q;
  assign dclick_o = dclick_q;
  assign long_o   = long_q;
  assign busy_o   = (state_q != IDLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scenario bench for button_event_decoder with LONG_TIME=8, GAP_TIME=6.
// Expected pulses are queued with their cycle number and matched against observed pulses.
module tb_button_event_decoder;

  typedef struct packed {
    logic [2:0]  kind;  // {long, dclick, click}
    logic [31:0] cyc;
  } ev_t;

  logic       clk_i;
  logic       rst_i;
  logic       btn_i;
  logic       click_o;
  logic       dclick_o;
  logic       long_o;
  logic       busy_o;
  logic [2:0] state_o;

  int  cyc;
  int  checks;
  int  errors;
  ev_t exp_q[$];
  ev_t obs_q[$];

  button_event_decoder #(
    .LONG_TIME(32'd8),
    .GAP_TIME (32'd6)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_i),
    .click_o (click_o),
    .dclick_o(dclick_o),
    .long_o  (long_o),
    .busy_o  (busy_o),
    .state_o (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock edge and record any pulse seen just after it.
  task automatic tick();
    ev_t o;
    @(posedge clk_i);
    cyc++;
    #1;
    if (click_o | dclick_o | long_o) begin
      o.kind = {long_o, dclick_o, click_o};
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    btn_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_async_state got %0d want 0", state_o); end
    repeat (3) tick();
    checks++;
    if ({click_o, dclick_o, long_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b want 000", {click_o, dclick_o, long_o});
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    rst_i = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL reset_no_events got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_single_click();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(3'b001, c + 10);
    btn_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL single_press1 got state=%0d busy=%b want 1/1", state_o, busy_o);
    end
    btn_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL single_wait2 got %0d want 2", state_o); end
    repeat (12) tick();
    checks++;
    if (state_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL single_idle got state=%0d busy=%b want 0/0", state_o, busy_o);
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_double_click();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(3'b010, c + 8);
    btn_i = 1'b1;
    repeat (3) tick();
    btn_i = 1'b0;
    repeat (2) tick();
    btn_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL double_press2 got %0d want 3", state_o); end
    tick();
    btn_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL double_idle got %0d want 0", state_o); end
    repeat (10) tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL double_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_long_press();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(3'b100, c + 9);
    btn_i = 1'b1;
    repeat (20) tick();
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL long_held got %0d want 4", state_o); end
    btn_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL long_release got state=%0d busy=%b want 0/0", state_o, busy_o);
    end
    repeat (10) tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL long_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_release_at_limit();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(3'b001, c + 15);
    btn_i = 1'b1;
    repeat (8) tick();
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL limit_still_press1 got %0d want 1", state_o); end
    btn_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL limit_release_wait2 got %0d want 2", state_o); end
    repeat (10) tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL limit_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_press_at_gap_limit();
    ev_t e, o;
    int  c;
    c = cyc;
    expect_ev(3'b010, c + 12);
    btn_i = 1'b1;
    repeat (3) tick();
    btn_i = 1'b0;
    repeat (6) tick();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL gap_still_wait2 got %0d want 2", state_o); end
    btn_i = 1'b1;
    tick();
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL gap_press2 got %0d want 3", state_o); end
    tick();
    btn_i = 1'b0;
    repeat (5) tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gap_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_reset_in_wait2();
    btn_i = 1'b1;
    repeat (3) tick();
    btn_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL rstmid_pre_wait2 got %0d want 2", state_o); end
    rst_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_immediate got state=%0d busy=%b want 0/0", state_o, busy_o);
    end
    tick();
    rst_i = 1'b1;
    repeat (12) tick();
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_held_through_reset();
    ev_t e, o;
    int  c;
    btn_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    repeat (12) tick();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL held_state got %0d want 0", state_o); end
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL held_no_pulse got %0d want 0", obs_q.size()); end
    obs_q.delete();
    btn_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL held_release_idle got %0d want 0", state_o); end
    c = cyc;
    expect_ev(3'b001, c + 10);
    btn_i = 1'b1;
    repeat (3) tick();
    btn_i = 1'b0;
    repeat (10) tick();
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = '0; o = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL held_repress_event got kind=%b cyc=%0d want kind=%b cyc=%0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_single_click();
    test_double_click();
    test_long_press();
    test_release_at_limit();
    test_press_at_gap_limit();
    test_reset_in_wait2();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
